// File: rtl/pool_pkg.sv
// Shared types and helpers for the max-pooling sequencer: FSM state encoding,
// window-size limits and the signed compare used by the running max.
package pool_pkg;

    localparam int K_MAX  = 4;
    localparam int ELEM_W = $clog2(K_MAX * K_MAX);

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        ACCUM,
        WAIT,
        EMIT,
        FIN
    } state_t;

    // Callers sign-extend into int so one helper serves any data width up to 32.
    function automatic int signed_max(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Out-of-range edges are clamped (0 -> 1, >K_MAX -> K_MAX) before squaring.
    function automatic logic [ELEM_W-1:0] last_elem_idx(input logic [2:0] k);
        int kc;
        kc = (k == 3'd0) ? 1 : ((int'(k) > K_MAX) ? K_MAX : int'(k));
        return ELEM_W'(kc * kc - 1);
    endfunction

endpackage

// File: rtl/pool_win_counter.sv
// Element-within-window and window-within-job counters with the position flags
// the sequencer needs to decide first/last element and last window.
module pool_win_counter
    import pool_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic              clk,
    input  logic              master_rst,
    input  logic              clr,
    input  logic              elem_inc,
    input  logic              win_inc,
    input  logic [ELEM_W-1:0] last_idx,
    input  logic [CNT_W-1:0]  num_win,
    output logic              first_elem,
    output logic              last_elem,
    output logic              last_win
);

    logic [ELEM_W-1:0] elem_cnt;
    logic [CNT_W-1:0]  win_cnt;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge master_rst) begin
        if (master_rst) begin
            elem_cnt <= '0;
            win_cnt  <= '0;
        end else if (clr) begin
            elem_cnt <= '0;
            win_cnt  <= '0;
        end else begin
            if (elem_inc)
                elem_cnt <= last_elem ? '0 : elem_cnt + 1'b1;
            if (win_inc)
                win_cnt <= win_cnt + 1'b1;
        end
    end

    assign first_elem = (elem_cnt == '0);
    assign last_elem  = (elem_cnt == last_idx);
    assign last_win   = (win_cnt == num_win - 1'b1);

endmodule

// File: rtl/maxpool_seq_ctrl.sv
// Max-pooling sequencer: drives an external max register per window and emits one
// pooled value per window. Define POOL_RELU_EN to clamp negative pooled values to 0.
module maxpool_seq_ctrl
    import pool_pkg::*;
#(
    parameter int N     = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             master_rst,
    input  logic             start,
    input  logic [2:0]       cfg_k,
    input  logic [CNT_W-1:0] cfg_num_win,
    output logic             busy,
    output logic             done,
    input  logic             in_valid,
    input  logic [N-1:0]     in_data,
    output logic             in_ready,
    output logic             mr_ce,
    output logic             mr_rst_m,
    output logic [N-1:0]     mr_din,
    input  logic [N-1:0]     mr_q,
    output logic             out_valid,
    output logic [N-1:0]     out_data,
    input  logic             out_ready
);

    state_t            state;
    logic [ELEM_W-1:0] last_idx_q;
    logic [CNT_W-1:0]  num_win_q;
    logic              hs;
    logic              first_elem;
    logic              last_elem;
    logic              last_win;
    logic [N-1:0]      pooled;

    assign hs = in_valid & in_ready;

    // The max register must see the compare in the handshake cycle so back-to-back
    // pixels chain through mr_q; hence these three are decoded, not registered.
    assign mr_ce    = hs | (state == CLEAR);
    assign mr_rst_m = (state == CLEAR);
    assign mr_din   = !hs        ? '0 :
                      first_elem ? in_data :
                                   N'(signed_max(int'($signed(in_data)), int'($signed(mr_q))));

`ifdef POOL_RELU_EN
    assign pooled = mr_q[N-1] ? '0 : mr_q;
`else
    assign pooled = mr_q;
`endif

    pool_win_counter #(.CNT_W(CNT_W)) u_cnt (
        .clk        (clk),
        .master_rst (master_rst),
        .clr        (state == CLEAR),
        .elem_inc   (hs),
        .win_inc    ((state == EMIT) && out_ready),
        .last_idx   (last_idx_q),
        .num_win    (num_win_q),
        .first_elem (first_elem),
        .last_elem  (last_elem),
        .last_win   (last_win)
    );

    always_ff @(posedge clk or posedge master_rst) begin
        if (master_rst) begin
            state      <= IDLE;
            busy       <= 1'b0;
            done       <= 1'b0;
            in_ready   <= 1'b0;
            out_valid  <= 1'b0;
            out_data   <= '0;
            last_idx_q <= '0;
            num_win_q  <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    busy       <= 1'b1;
                    last_idx_q <= last_elem_idx(cfg_k);
                    num_win_q  <= cfg_num_win;
                    if (cfg_num_win == '0) begin
                        state <= FIN;
                        done  <= 1'b1;
                    end else begin
                        state <= CLEAR;
                    end
                end
                CLEAR: begin
                    state    <= ACCUM;
                    in_ready <= 1'b1;
                end
                ACCUM: if (hs && last_elem) begin
                    state    <= WAIT;
                    in_ready <= 1'b0;
                end
                // mr_q now holds the window max; capture it for the whole EMIT phase.
                WAIT: begin
                    state     <= EMIT;
                    out_valid <= 1'b1;
                    out_data  <= pooled;
                end
                EMIT: if (out_ready) begin
                    out_valid <= 1'b0;
                    if (last_win) begin
                        state <= FIN;
                        done  <= 1'b1;
                    end else begin
                        state    <= ACCUM;
                        in_ready <= 1'b1;
                    end
                end
                FIN: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_maxpool_seq_ctrl.sv
// Self-checking bench for maxpool_seq_ctrl paired with a behavioural max register;
// honours POOL_RELU_EN in its expected values.
module tb_maxpool_seq_ctrl;

    logic        clk = 1'b0;
    logic        master_rst;
    logic        start;
    logic [2:0]  cfg_k;
    logic [15:0] cfg_num_win;
    logic        busy, done;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        mr_ce, mr_rst_m;
    logic [7:0]  mr_din;
    logic [7:0]  mr_q = '0;
    logic        out_valid;
    logic [7:0]  out_data;
    logic        out_ready;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    maxpool_seq_ctrl dut (
        .clk         (clk),
        .master_rst  (master_rst),
        .start       (start),
        .cfg_k       (cfg_k),
        .cfg_num_win (cfg_num_win),
        .busy        (busy),
        .done        (done),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .in_ready    (in_ready),
        .mr_ce       (mr_ce),
        .mr_rst_m    (mr_rst_m),
        .mr_din      (mr_din),
        .mr_q        (mr_q),
        .out_valid   (out_valid),
        .out_data    (out_data),
        .out_ready   (out_ready)
    );

    // External max register: clear or load when enabled, one cycle to mr_q.
    always @(posedge clk)
        if (mr_ce) mr_q <= mr_rst_m ? 8'd0 : mr_din;

    task automatic check(input string name, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    function automatic int post(input int v);
`ifdef POOL_RELU_EN
        return (v < 0) ? 0 : v;
`else
        return v;
`endif
    endfunction

    function automatic int sx(input logic [7:0] v);
        return int'($signed(v));
    endfunction

    // Reference: clamp the edge, split the stream into k*k windows, take each max.
    function automatic void model(input int k, input int nw, input int px[$], output int ex[$]);
        int kk, m;
        kk = (k == 0) ? 1 : ((k > 4) ? 4 : k);
        kk = kk * kk;
        ex = {};
        for (int w = 0; w < nw; w++) begin
            m = px[w * kk];
            for (int e = 1; e < kk; e++)
                if (px[w * kk + e] > m) m = px[w * kk + e];
            ex.push_back(post(m));
        end
    endfunction

    task automatic run_job(input string name, input int k, input int nw, input int px[$],
                           input int ex[$], input int valid_pct, input int ready_pct,
                           input int stall_n, input int poke_cyc);
        int idx = 0, oidx = 0, cyc = 0, last_hs = -100, stall_left = 0;
        bit prev_ov = 0, prev_stalled = 0, fin = 0;
        logic [7:0] held = '0;
        @(negedge clk);
        start = 1'b1; cfg_k = 3'(k); cfg_num_win = 16'(nw);
        @(negedge clk);
        start = 1'b0;
        check({name, " busy_on_start"}, int'(busy), 1);
        while (!fin && cyc < 4000) begin
            if (done) fin = 1;
            if (out_valid && prev_stalled)
                check({name, " out_data_stable"}, sx(out_data), sx(held));
            if (out_valid && !prev_ov) begin
                check({name, " latency"}, cyc, last_hs + 2);
                stall_left = stall_n;
            end
            if (out_valid)
                check({name, " in_ready_in_emit"}, int'(in_ready), 0);
            if (cyc == poke_cyc) begin
                start = 1'b1; cfg_k = 3'(k == 1 ? 2 : 1);
            end else begin
                start = 1'b0;
            end
            in_valid = (idx < px.size()) && ($urandom_range(99) < valid_pct);
            in_data  = in_valid ? 8'(px[idx]) : 8'($urandom);
            if (in_valid && in_ready) begin
                idx++;
                last_hs = cyc;
            end
            if (out_valid && stall_left > 0) begin
                out_ready = 1'b0;
                stall_left--;
            end else begin
                out_ready = ($urandom_range(99) < ready_pct);
            end
            if (out_valid && out_ready) begin
                check({name, " out_data"}, sx(out_data), (oidx < ex.size()) ? ex[oidx] : 9999);
                oidx++;
            end
            if (out_valid && !out_ready) held = out_data;
            prev_stalled = out_valid && !out_ready;
            prev_ov = out_valid;
            if (!fin) begin
                @(negedge clk);
                cyc++;
            end
        end
        in_valid = 1'b0; out_ready = 1'b0; start = 1'b0;
        check({name, " done_seen"}, int'(fin), 1);
        check({name, " outputs_count"}, oidx, ex.size());
        check({name, " pixels_consumed"}, idx, px.size());
        @(negedge clk);
        check({name, " done_one_cycle"}, int'(done), 0);
        check({name, " busy_after_done"}, int'(busy), 0);
    endtask

    typedef struct {
        int k;
        int nw;
        int off;
        int n;
        int ex[4];
    } vec_t;

    initial begin
        vec_t vecs[5];
        int   pool[$];
        int   px[$];
        int   ex[$];
        int   k, nw, kk;

        master_rst = 1'b1; start = 1'b0; cfg_k = '0; cfg_num_win = '0;
        in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        #2;
        check("rst busy", int'(busy), 0);
        check("rst done", int'(done), 0);
        check("rst in_ready", int'(in_ready), 0);
        check("rst mr_ce", int'(mr_ce), 0);
        check("rst mr_rst_m", int'(mr_rst_m), 0);
        check("rst mr_din", int'(mr_din), 0);
        check("rst out_valid", int'(out_valid), 0);
        check("rst out_data", int'(out_data), 0);
        repeat (2) @(negedge clk);
        master_rst = 1'b0;

        pool = {3, -5, 7, 1, -8, -2, -9, -4,
                5, -3, 127, -128,
                9, -1,
                -20, -7, -100, -3, -50, -60, -8, -9, -10, -11, -12, -13, -14, -15, -16, -17,
                -128, -1, 0, 126, 127, -127, 5, 6, 7};
        vecs[0] = '{k: 2, nw: 2, off: 0,  n: 8,  ex: '{7, -2, 0, 0}};
        vecs[1] = '{k: 1, nw: 4, off: 8,  n: 4,  ex: '{5, -3, 127, -128}};
        vecs[2] = '{k: 0, nw: 2, off: 12, n: 2,  ex: '{9, -1, 0, 0}};
        vecs[3] = '{k: 6, nw: 1, off: 14, n: 16, ex: '{-3, 0, 0, 0}};
        vecs[4] = '{k: 3, nw: 1, off: 30, n: 9,  ex: '{127, 0, 0, 0}};
        for (int v = 0; v < 5; v++) begin
            px = {};
            ex = {};
            for (int i = 0; i < vecs[v].n; i++) px.push_back(pool[vecs[v].off + i]);
            for (int w = 0; w < vecs[v].nw; w++) ex.push_back(post(vecs[v].ex[w]));
            run_job($sformatf("vec%0d", v), vecs[v].k, vecs[v].nw, px, ex, 100, 100, 0, -1);
        end

        // Bubbly input with a 5-cycle output stall on every window.
        px = {};
        for (int i = 0; i < 18; i++) px.push_back(sx(8'($urandom)));
        model(3, 2, px, ex);
        run_job("stall", 3, 2, px, ex, 50, 100, 5, -1);

        // start while busy carries a different edge; the original one must stick.
        px = {3, -5, 7, 1, -8, -2, -9, -4};
        model(2, 2, px, ex);
        run_job("busy_start", 2, 2, px, ex, 100, 100, 0, 3);

        // Zero windows: done one cycle after start, nothing emitted.
        @(negedge clk);
        start = 1'b1; cfg_k = 3'd2; cfg_num_win = '0;
        @(negedge clk);
        start = 1'b0;
        check("nw0 done", int'(done), 1);
        check("nw0 busy", int'(busy), 1);
        check("nw0 out_valid", int'(out_valid), 0);
        @(negedge clk);
        check("nw0 done_low", int'(done), 0);
        check("nw0 busy_low", int'(busy), 0);
        check("nw0 out_valid_low", int'(out_valid), 0);

        // Reset after two of four elements of a window.
        @(negedge clk);
        start = 1'b1; cfg_k = 3'd2; cfg_num_win = 16'd1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        in_valid = 1'b1; in_data = 8'd50;
        @(negedge clk);
        in_data = 8'd60;
        @(negedge clk);
        in_data = 8'd70;
        master_rst = 1'b1;
        #1;
        check("midrst busy", int'(busy), 0);
        check("midrst done", int'(done), 0);
        check("midrst in_ready", int'(in_ready), 0);
        check("midrst mr_ce", int'(mr_ce), 0);
        check("midrst mr_rst_m", int'(mr_rst_m), 0);
        check("midrst mr_din", int'(mr_din), 0);
        check("midrst out_valid", int'(out_valid), 0);
        check("midrst out_data", int'(out_data), 0);
        @(negedge clk);
        in_valid = 1'b0;
        master_rst = 1'b0;
        run_job("after_rst", 2, 1, '{-1, -2, -3, -4}, '{post(-1)}, 100, 100, 0, -1);

        // Randomised jobs, including out-of-range edges that must clamp.
        for (int j = 0; j < 6; j++) begin
            k  = $urandom_range(0, 6);
            nw = $urandom_range(1, 3);
            kk = (k == 0) ? 1 : ((k > 4) ? 4 : k);
            px = {};
            for (int i = 0; i < kk * kk * nw; i++) px.push_back(sx(8'($urandom)));
            model(k, nw, px, ex);
            run_job($sformatf("rand%0d", j), k, nw, px, ex, 70, 70, 0, -1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
